// File: rtl/kirby_line_fetch.sv
// kirby_line_fetch: per-line sprite fetch for the Kirby sprite.
// During horizontal blank, the next line's sprite row is copied from the
// synchronous sprite ROM into a SPRITE_W-entry line buffer. During the
// following active line, that buffer is served combinationally, indexed by
// DrawX. Palette index 0 is transparent.
module kirby_line_fetch #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int N_FRAMES = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ROM_AW   = 12,
  parameter int ROM_LAT  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              hblank_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        Kirby_X,
  input  logic [9:0]        Kirby_Y,
  input  logic [1:0]        Kirby_frame,
  input  logic              Kirby_flip,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [3:0]        rom_data,
  output logic [3:0]        idx_kirby,
  output logic              busy
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  // Parameter sanity, evaluated once at elaboration.
  if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_bad_lat
    $error("kirby_line_fetch: ROM_LAT must be 1 or 2");
  end
  if (N_FRAMES * SPRITE_W * SPRITE_H > (1 << ROM_AW)) begin : g_bad_rom
    $error("kirby_line_fetch: sprite frames do not fit in ROM_AW address bits");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_start_fetch;
  logic               w_drain_done;
  logic               w_abort;

  // Per-frame shadow copies of the sprite position and pose.
  logic [9:0]         r_x_s;
  logic [9:0]         r_y_s;
  logic [1:0]         r_f_s;
  logic               r_flip_s;
  logic               r_line_valid;

  // Fetch counters.
  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [1:0]         r_drain;

  // Write delay line that tracks outstanding ROM reads.
  logic [ROM_LAT-1:0]         r_pipe_v;
  logic [ROM_LAT-1:0][CW-1:0] r_pipe_col;
  logic                       w_buf_we;

  logic [3:0]         r_buf [SPRITE_W];

  // Row test signals.
  logic [9:0]         w_y_sel;
  logic [10:0]        w_ny;
  logic [10:0]        w_y_top;
  logic [10:0]        w_y_end;
  logic               w_hit;
  logic [RW-1:0]      w_row;

  // Pixel output signals.
  logic [10:0]        w_c;
  logic [CW-1:0]      w_c_lo;
  logic [CW-1:0]      w_buf_idx;

  // If frame_start and hblank_start coincide, the row test uses the Y value
  // being latched this cycle. Otherwise it uses the frame's shadow copy.
  assign w_y_sel = frame_start ? Kirby_Y : r_y_s;
  assign w_ny    = {1'b0, DrawY} + 11'd1;
  assign w_y_top = {1'b0, w_y_sel};
  assign w_y_end = w_y_top + 11'(SPRITE_H);
  assign w_hit   = (w_ny < 11'(V_ACTIVE)) && (w_ny >= w_y_top) && (w_ny < w_y_end);
  assign w_row   = RW'(w_ny - w_y_top);

  // frame_start kills a fetch that is in progress.
  assign w_abort = frame_start && (r_state != S_IDLE);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so that every flop samples
  // pre-edge values. Blocking assignments here would create order-dependent races.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and Moore outputs (ROM strobe, address, busy).
  // NOTE: every output of this block gets a default value before the case.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_start_fetch = 1'b0;
    w_drain_done  = 1'b0;
    rom_rd        = 1'b0;
    rom_addr      = '0;
    busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hblank_start && w_hit) begin
          w_next_state  = S_FETCH;
          w_start_fetch = 1'b1;
        end
      end
      S_FETCH: begin
        rom_rd   = 1'b1;
        busy     = 1'b1;
        // SPRITE_W and SPRITE_H are powers of two, so concatenation equals
        // F*W*H + r*W + col.
        rom_addr = ROM_AW'({r_f_s, r_row, r_col});
        if (r_col == CW'(SPRITE_W - 1)) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_drain == 2'(ROM_LAT - 1)) begin
          w_next_state = S_IDLE;
          w_drain_done = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = S_IDLE;
      w_drain_done = 1'b0;
    end
  end

  // Latch the sprite pose once per frame and track line buffer validity.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x_s        <= '0;
      r_y_s        <= '0;
      r_f_s        <= '0;
      r_flip_s     <= 1'b0;
      r_line_valid <= 1'b0;
    end else begin
      if (frame_start) begin
        r_x_s    <= Kirby_X;
        r_y_s    <= Kirby_Y;
        r_f_s    <= Kirby_frame;
        r_flip_s <= Kirby_flip;
      end
      if (frame_start)                              r_line_valid <= 1'b0;
      else if (r_state == S_IDLE && hblank_start)   r_line_valid <= 1'b0;
      else if (w_drain_done)                        r_line_valid <= 1'b1;
    end
  end

  // Column, row and drain counters for the fetch sequence.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      if (w_start_fetch) begin
        r_col <= '0;
        r_row <= w_row;
      end else if (r_state == S_FETCH) begin
        r_col <= r_col + CW'(1);
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + 2'd1;
      else                    r_drain <= '0;
    end
  end

  // Delay each issued column by ROM_LAT cycles so it arrives with its data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pipe_v   <= '0;
      r_pipe_col <= '0;
    end else if (w_abort) begin
      r_pipe_v <= '0;
    end else begin
      r_pipe_v[0]   <= rom_rd;
      r_pipe_col[0] <= r_col;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_col[i] <= r_pipe_col[i-1];
      end
    end
  end

  // A return that lands in the same cycle as an abort belongs to the
  // cancelled fetch, so it is dropped.
  assign w_buf_we = r_pipe_v[ROM_LAT-1] && !w_abort;

  // Line buffer write port.
  // NOTE: this small buffer is built from flops and must come out of reset
  // all zero (transparent). Large RAM arrays normally have no reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SPRITE_W; i++) r_buf[i] <= '0;
    end else if (w_buf_we) begin
      r_buf[r_pipe_col[ROM_LAT-1]] <= rom_data;
    end
  end

  // Sprite column under DrawX. Positions left of the sprite wrap to large
  // unsigned values, so a single unsigned compare covers 0 <= c < SPRITE_W.
  assign w_c       = {1'b0, DrawX} - {1'b0, r_x_s};
  assign w_c_lo    = CW'(w_c);
  assign w_buf_idx = r_flip_s ? (CW'(SPRITE_W - 1) - w_c_lo) : w_c_lo;

  // Combinational pixel lookup. Outside the sprite or visible area, the output is transparent.
  always_comb begin
    idx_kirby = '0;
    if (r_line_valid && (DrawX < 10'(H_ACTIVE)) && (w_c < 11'(SPRITE_W)))
      idx_kirby = r_buf[w_buf_idx];
  end

endmodule

// File: tb/tb_kirby_line_fetch.sv
module tb_kirby_line_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       hblank_start = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] Kirby_X = '0;
  logic [9:0] Kirby_Y = '0;
  logic [1:0] Kirby_frame = '0;
  logic       Kirby_flip = 1'b0;

  logic [11:0] rom_addr1, rom_addr2;
  logic        rom_rd1, rom_rd2;
  logic [3:0]  rom_data1, rom_data2;
  logic [3:0]  idx1, idx2;
  logic        busy1, busy2;

  always #10 Clk = ~Clk;

  kirby_line_fetch #(.ROM_LAT(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .hblank_start(hblank_start),
    .DrawX(DrawX), .DrawY(DrawY), .Kirby_X(Kirby_X), .Kirby_Y(Kirby_Y),
    .Kirby_frame(Kirby_frame), .Kirby_flip(Kirby_flip),
    .rom_addr(rom_addr1), .rom_rd(rom_rd1), .rom_data(rom_data1),
    .idx_kirby(idx1), .busy(busy1)
  );

  kirby_line_fetch #(.ROM_LAT(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .hblank_start(hblank_start),
    .DrawX(DrawX), .DrawY(DrawY), .Kirby_X(Kirby_X), .Kirby_Y(Kirby_Y),
    .Kirby_frame(Kirby_frame), .Kirby_flip(Kirby_flip),
    .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_data(rom_data2),
    .idx_kirby(idx2), .busy(busy2)
  );

  // Sprite ROM image: low nibble of the column, mixed with the column MSB and
  // the row bits, so that row errors and flip errors both change the pixels.
  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    return a[3:0] ^ {a[4], a[7:5]};
  endfunction

  // Synchronous ROM models with latency 1 and latency 2.
  logic [3:0] rom1_q, rom2_q1, rom2_q2;
  always @(posedge Clk) begin
    rom1_q  <= rom_fn(rom_addr1);
    rom2_q1 <= rom_fn(rom_addr2);
    rom2_q2 <= rom2_q1;
  end
  assign rom_data1 = rom1_q;
  assign rom_data2 = rom2_q2;

  // Observed DUT, selected by sel.
  bit          sel = 1'b0;
  logic        rd_s, busy_s;
  logic [11:0] addr_s;
  logic [3:0]  idx_s;
  assign rd_s   = sel ? rom_rd2   : rom_rd1;
  assign busy_s = sel ? busy2     : busy1;
  assign addr_s = sel ? rom_addr2 : rom_addr1;
  assign idx_s  = sel ? idx2      : idx1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the visible line.
  int         m_x     = 0;
  bit         m_flip  = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] m_line [32];

  // Scoreboard of the expected ROM read addresses.
  logic [11:0] exp_q [$];

  function automatic logic [3:0] exp_idx(input int x);
    int c;
    c = x - m_x;
    if (!m_valid || x >= 640 || c < 0 || c >= 32) return 4'd0;
    return m_line[m_flip ? 31 - c : c];
  endfunction

  task automatic new_frame(input int x, input int y, input int f, input bit fl);
    repeat (2) @(negedge Clk);
    Kirby_X = 10'(x); Kirby_Y = 10'(y); Kirby_frame = 2'(f); Kirby_flip = fl;
    DrawY = 10'd490; DrawX = 10'd0;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    m_x = x; m_flip = fl; m_valid = 1'b0;
  endtask

  task automatic hblank(input int dy);
    repeat (2) @(negedge Clk);
    DrawY = 10'(dy); DrawX = 10'd640;
    hblank_start = 1'b1;
    @(negedge Clk);
    hblank_start = 1'b0;
  endtask

  // Push the expected addresses for a row fetch. Update the line model as well.
  task automatic sb_push_row(input int f, input int r);
    logic [11:0] a;
    for (int c = 0; c < 32; c++) begin
      a = 12'(f * 1024 + r * 32 + c);
      exp_q.push_back(a);
      m_line[c] = rom_fn(a);
    end
    m_valid = 1'b1;
  endtask

  // Consume the scoreboard while the selected DUT is busy.
  task automatic sb_drain(input string tag, input int lat);
    int rd_n = 0;
    int busy_n = 0;
    int t = 0;
    logic [11:0] e;
    while (busy_s && t < 200) begin
      if (rd_s) begin
        rd_n++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_rd: rom_rd high with addr %0d, no read expected", tag, addr_s);
        end else begin
          e = exp_q.pop_front();
          if (addr_s !== e) $display("FAIL %s_addr: got %0d expected %0d", tag, addr_s, e);
          else n_pass++;
        end
      end
      busy_n++;
      @(negedge Clk);
      t++;
    end
    n_checks++;
    if (rd_n !== 32) $display("FAIL %s_rd_cycles: got %0d expected 32", tag, rd_n);
    else n_pass++;
    n_checks++;
    if (busy_n !== 32 + lat) $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_n, 32 + lat);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_missing_reads: got %0d left expected 0", tag, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic expect_no_fetch(input string tag, input int dy);
    bit seen = 1'b0;
    hblank(dy);
    m_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rd_s || busy_s) seen = 1'b1;
      @(negedge Clk);
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL %s_no_fetch: got fetch expected none", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    DrawX = 10'd0;
    repeat (3) @(negedge Clk);
    n_checks++; if (rd_s !== 1'b0)    $display("FAIL reset_rd: got %b expected 0", rd_s);     else n_pass++;
    n_checks++; if (busy_s !== 1'b0)  $display("FAIL reset_busy: got %b expected 0", busy_s); else n_pass++;
    n_checks++; if (addr_s !== 12'd0) $display("FAIL reset_addr: got %0d expected 0", addr_s); else n_pass++;
    n_checks++; if (idx_s !== 4'd0)   $display("FAIL reset_idx: got %0d expected 0", idx_s);   else n_pass++;
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) m_line[i] = 4'd0;
  endtask

  task automatic test_basic();
    int xs [5] = '{99, 100, 101, 131, 132};
    logic [3:0] e4;
    new_frame(100, 50, 2, 1'b0);
    sb_push_row(2, 0);
    hblank(49);
    sb_drain("basic_row0", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL basic_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
    // A mid-frame position change must not move the sprite.
    Kirby_X = 10'd300;
    Kirby_Y = 10'd0;
    sb_push_row(2, 1);
    hblank(50);
    sb_drain("basic_row1", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL midframe_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
    @(negedge Clk); DrawX = 10'd300; #1;
    n_checks++;
    if (idx_s !== 4'd0) $display("FAIL midframe_newx: got %0d expected 0", idx_s); else n_pass++;
    expect_no_fetch("basic_above", 10);
    @(negedge Clk); DrawX = 10'd101; #1;
    n_checks++;
    if (idx_s !== 4'd0) $display("FAIL basic_cleared: got %0d expected 0", idx_s); else n_pass++;
  endtask

  task automatic test_flip();
    int xs [4] = '{100, 101, 130, 131};
    logic [3:0] e4;
    new_frame(100, 50, 1, 1'b1);
    sb_push_row(1, 0);
    hblank(49);
    sb_drain("flip_row0", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL flip_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
    // Last sprite row, then the first line below the sprite.
    sb_push_row(1, 31);
    hblank(80);
    sb_drain("flip_row31", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL flip31_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
    expect_no_fetch("flip_below", 81);
  endtask

  task automatic test_edges();
    int xs [5] = '{619, 620, 630, 639, 640};
    logic [3:0] e4;
    new_frame(620, 470, 3, 1'b0);
    sb_push_row(3, 0);
    hblank(469);
    sb_drain("edge_row0", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL edge_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
    sb_push_row(3, 9);
    hblank(478);
    sb_drain("edge_row9", 1);
    @(negedge Clk); DrawX = 10'd625; #1;
    e4 = exp_idx(625);
    n_checks++;
    if (idx_s !== e4) $display("FAIL edge_row9_pix: got %0d expected %0d", idx_s, e4); else n_pass++;
    expect_no_fetch("edge_bottom", 479);
  endtask

  task automatic test_abort();
    int xs [4] = '{200, 215, 231, 232};
    logic [3:0] e4;
    new_frame(100, 50, 0, 1'b0);
    hblank(49);
    repeat (10) @(negedge Clk);
    Kirby_X = 10'd200; Kirby_Y = 10'd300; Kirby_frame = 2'd3; Kirby_flip = 1'b0;
    DrawY = 10'd60;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    m_x = 200; m_flip = 1'b0; m_valid = 1'b0;
    n_checks++; if (rd_s !== 1'b0)   $display("FAIL abort_rd: got %b expected 0", rd_s);     else n_pass++;
    n_checks++; if (busy_s !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_s); else n_pass++;
    DrawX = 10'd210; #1;
    n_checks++; if (idx_s !== 4'd0)  $display("FAIL abort_idx: got %0d expected 0", idx_s);  else n_pass++;
    sb_push_row(3, 0);
    hblank(299);
    sb_drain("abort_refetch", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL abort_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int xs [3] = '{50, 60, 81};
    logic [3:0] e4;
    for (int lat = 1; lat <= 2; lat++) begin
      sel = (lat == 2);
      repeat (4) @(negedge Clk);
      Kirby_X = 10'd50; Kirby_Y = 10'd200; Kirby_frame = 2'd1; Kirby_flip = 1'b0;
      sb_push_row(1, 0);
      DrawY = 10'd199; DrawX = 10'd640;
      frame_start = 1'b1; hblank_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0; hblank_start = 1'b0;
      m_x = 50; m_flip = 1'b0;
      sb_drain(lat == 1 ? "simul_lat1" : "simul_lat2", lat);
      foreach (xs[i]) begin
        @(negedge Clk); DrawX = 10'(xs[i]); #1;
        e4 = exp_idx(xs[i]);
        n_checks++;
        if (idx_s !== e4) $display("FAIL simul_pix lat=%0d x=%0d: got %0d expected %0d", lat, xs[i], idx_s, e4);
        else n_pass++;
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int xs [3] = '{0, 31, 32};
    logic [3:0] e4;
    new_frame(100, 50, 2, 1'b1);
    hblank(49);
    repeat (5) @(negedge Clk);
    DrawX = 10'd101;
    #2 Reset = 1'b1;
    #1;
    n_checks++; if (rd_s !== 1'b0)   $display("FAIL rstmid_rd: got %b expected 0", rd_s);     else n_pass++;
    n_checks++; if (busy_s !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_s); else n_pass++;
    n_checks++; if (idx_s !== 4'd0)  $display("FAIL rstmid_idx: got %0d expected 0", idx_s);  else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    m_x = 0; m_flip = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_line[i] = 4'd0;
    expect_no_fetch("rstmid_far", 100);
    sb_push_row(0, 6);
    hblank(5);
    sb_drain("rstmid_row6", 1);
    foreach (xs[i]) begin
      @(negedge Clk); DrawX = 10'(xs[i]); #1;
      e4 = exp_idx(xs[i]);
      n_checks++;
      if (idx_s !== e4) $display("FAIL rstmid_pix x=%0d: got %0d expected %0d", xs[i], idx_s, e4);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_edges();
    test_abort();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
